// File: rtl/lfsr_checker_if.sv
// Stream and status bundle between a PRBS source/monitor and lfsr_checker.
// The checker drives the status side; CNT_WIDTH must match the checker's CNT_WIDTH.
interface lfsr_checker_if #(
  parameter int CNT_WIDTH = 32
);
  logic                 in_valid;
  logic                 in_bit;
  logic                 err_clr;
  logic                 locked;
  logic                 err;
  logic                 lock_lost;
  logic [CNT_WIDTH-1:0] error_count;

  modport master (
    output in_valid, in_bit, err_clr,
    input  locked, err, lock_lost, error_count
  );

  modport slave (
    input  in_valid, in_bit, err_clr,
    output locked, err, lock_lost, error_count
  );
endinterface

// File: rtl/lfsr_checker.sv
// Self-synchronising PRBS checker: seeds a local copy of the generator LFSR from
// the stream, then predicts each bit and tracks lock, bit errors and error rate.
//
// state     | meaning
// ----------+-------------------------------------------------------------
// ST_SEED   | shifting raw stream bits into r until WIDTH bits collected
// ST_VERIFY | r free-runs; need LOCK_COUNT consecutive matches to lock
// ST_LOCKED | r free-runs; mismatches counted per WINDOW, drop at ERR_LIMIT
module lfsr_checker #(
  parameter int               WIDTH      = 16,
  parameter logic [WIDTH-1:0] FEEDBACK   = 16'h002D,
  parameter int               LOCK_COUNT = 32,
  parameter int               WINDOW     = 256,
  parameter int               ERR_LIMIT  = 16,
  parameter int               CNT_WIDTH  = 32
) (
  input  logic          clk,
  input  logic          rst,
  lfsr_checker_if.slave bus
);

  localparam int SW = (WIDTH > 1)      ? $clog2(WIDTH)      : 1;
  localparam int MW = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT) : 1;
  localparam int WW = (WINDOW > 1)     ? $clog2(WINDOW)     : 1;
  localparam int EW = (ERR_LIMIT > 1)  ? $clog2(ERR_LIMIT)  : 1;

  localparam logic [SW-1:0] SEED_LOAD  = SW'(WIDTH - 1);
  localparam logic [MW-1:0] MATCH_LOAD = MW'(LOCK_COUNT - 1);
  localparam logic [WW-1:0] WIN_LOAD   = WW'(WINDOW - 1);
  localparam logic [EW-1:0] ERR_LAST   = EW'(ERR_LIMIT - 1);

  typedef enum logic [1:0] {
    ST_SEED   = 2'd0,
    ST_VERIFY = 2'd1,
    ST_LOCKED = 2'd2
  } state_t;

  state_t               state;
  logic [WIDTH-1:0]     r;
  logic [SW-1:0]        seed_left;
  logic [MW-1:0]        match_left;
  logic [WW-1:0]        win_left;
  logic [EW-1:0]        win_errs;
  logic                 locked_q;
  logic                 err_q;
  logic                 lock_lost_q;
  logic [CNT_WIDTH-1:0] error_count_q;

  logic             exp_bit;
  logic [WIDTH-1:0] r_seed;
  logic [WIDTH-1:0] r_pred;
  logic             bit_match;
  logic             bit_err;

  always_comb begin
    exp_bit   = ^(r & FEEDBACK);
    r_seed    = {bus.in_bit, r[WIDTH-1:1]};
    r_pred    = {exp_bit, r[WIDTH-1:1]};
    bit_match = (bus.in_bit == exp_bit);
    bit_err   = bus.in_valid && (state == ST_LOCKED) && !bit_match;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= ST_SEED;
      r             <= '0;
      seed_left     <= SEED_LOAD;
      match_left    <= MATCH_LOAD;
      win_left      <= WIN_LOAD;
      win_errs      <= '0;
      locked_q      <= 1'b0;
      err_q         <= 1'b0;
      lock_lost_q   <= 1'b0;
      error_count_q <= '0;
    end else begin
      err_q       <= 1'b0;
      lock_lost_q <= 1'b0;

      // Clear has priority over a coincident increment.
      if (bus.err_clr) begin
        error_count_q <= '0;
      end else if (bit_err && !(&error_count_q)) begin
        error_count_q <= error_count_q + 1'b1;
      end

      if (bus.in_valid) begin
        case (state)
          ST_SEED: begin
            r <= r_seed;
            if (seed_left == '0) begin
              seed_left <= SEED_LOAD;
              // An all-zero seed is the LFSR lock-up state; keep collecting.
              if (r_seed != '0) begin
                state      <= ST_VERIFY;
                match_left <= MATCH_LOAD;
              end
            end else begin
              seed_left <= seed_left - 1'b1;
            end
          end

          ST_VERIFY: begin
            r <= r_pred;
            if (bit_match) begin
              if (match_left == '0) begin
                state    <= ST_LOCKED;
                locked_q <= 1'b1;
                win_left <= WIN_LOAD;
                win_errs <= '0;
              end else begin
                match_left <= match_left - 1'b1;
              end
            end else begin
              state     <= ST_SEED;
              seed_left <= SEED_LOAD;
            end
          end

          ST_LOCKED: begin
            r     <= r_pred;
            err_q <= !bit_match;
            // Reaching the limit takes precedence over the window wrap.
            if (!bit_match && (win_errs == ERR_LAST)) begin
              state       <= ST_SEED;
              seed_left   <= SEED_LOAD;
              locked_q    <= 1'b0;
              lock_lost_q <= 1'b1;
            end else if (win_left == '0) begin
              win_left <= WIN_LOAD;
              win_errs <= '0;
            end else begin
              win_left <= win_left - 1'b1;
              if (!bit_match) begin
                win_errs <= win_errs + 1'b1;
              end
            end
          end

          default: begin
            state     <= ST_SEED;
            seed_left <= SEED_LOAD;
            locked_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.locked      = locked_q;
  assign bus.err         = err_q;
  assign bus.lock_lost   = lock_lost_q;
  assign bus.error_count = error_count_q;

endmodule
